tsm_inner_anf_seq: RTL and testbench
====================================

TSM_INNER_ANF_SEQ -- requirements
Module: tsm_inner_anf_seq

Interface
REQ-001 Parameter NUM_SHARES, default 3, number of share domains evaluated; legal range 2..8.
REQ-002 Parameter NUM_OUT, default 8, number of output coordinate functions; legal range 1..8.
REQ-003 Parameter CLEAR_BETWEEN, default 1, inserts one idle/zero cycle between domain evaluations when 1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  producer offers in_mono.
REQ-007 in_ready  output  1  block can accept in_mono.
REQ-008 in_mono  input  NUM_SHARES*30  monomial shares; slice d = bits [30d+29:30d].
REQ-009 cfg_we  input  1  coefficient write strobe.
REQ-010 cfg_addr  input  3  output index k being written.
REQ-011 cfg_data  input  30  ANF coefficient mask for output k.
REQ-012 cfg_busy  output  1  high when state is not IDLE.
REQ-013 out_valid  output  1  out_bits holds a complete result.
REQ-014 out_ready  input  1  consumer accepts out_bits.
REQ-015 out_bits  output  NUM_SHARES*NUM_OUT  result; bit d*NUM_OUT+k = output k of domain d.

Function
REQ-016 Monomial bit order within each 30-bit slice SHALL be: bits 0..14 = x0,x1,x2,x3,x0x1,x0x2,x0x3,x1x2,x1x3,x2x3,x0x1x2,x0x1x3,x0x2x3,x1x2x3,x0x1x2x3; bits 15..29 = same pattern over x4..x7.
REQ-017 Output k of domain d SHALL equal XOR-reduction of (coef[k] AND mono_buf slice d).
REQ-018 Coefficient table coef[0..NUM_OUT-1], 30 bits each, SHALL be written on an edge with cfg_we=1 and state IDLE; cfg_addr >= NUM_OUT, or any write outside IDLE, SHALL be ignored.
REQ-019 FSM states SHALL be IDLE, EVAL, CLR, DONE.
REQ-020 IDLE: in_ready=1; on in_valid=1, capture in_mono into mono_buf, set dom=0, go to EVAL.
REQ-021 EVAL: write the NUM_OUT results of domain dom into out_bits, zero mono_buf slice dom; if dom=NUM_SHARES-1 go to DONE; else if CLEAR_BETWEEN=1 go to CLR; else increment dom, stay in EVAL.
REQ-022 CLR: no evaluation, combinational evaluation operand forced to zero; increment dom, go to EVAL.
REQ-023 Only slice dom of mono_buf SHALL reach the parity logic in EVAL; operand SHALL be all-zero in IDLE, CLR, DONE.
REQ-024 DONE: out_valid=1, out_bits stable; on out_ready=1 go to IDLE, out_valid low next cycle, out_bits retained.
REQ-025 Latency: with acceptance at edge E0, out_valid SHALL rise after edge E0 + NUM_SHARES + (NUM_SHARES-1)*CLEAR_BETWEEN (N=3,C=1: E0+5; N=3,C=0: E0+3).
REQ-026 in_ready SHALL be 0 in EVAL, CLR, DONE; in_valid there SHALL be ignored (no buffering).
REQ-027 cfg_we together with acceptance on the same IDLE edge: the write SHALL take effect, and the evaluation SHALL use the new coefficient.
REQ-028 out_ready while not in DONE SHALL be ignored.

Reset
REQ-029 rst=1 at any edge, including mid-evaluation, SHALL force IDLE, dom=0, mono_buf=0, out_bits=0, coef table=0, out_valid=0; in_ready SHALL be 1 and cfg_busy 0 from the first cycle after rst deasserts.
REQ-030 A transaction interrupted by reset SHALL produce no out_valid.

Verification
REQ-031 N=3,C=1; coef[0]=30'h1; in_mono slices {d2,d1,d0}={30'h1,30'h0,30'h1} -> after E0+5 out_valid=1, out_bits[0]=1, out_bits[8]=0, out_bits[16]=1, all other bits 0.
REQ-032 coef[1]=30'h3FFFFFFF, slice0=30'h7, slice1=30'h3, slice2=30'h0 -> out_bits[1]=1, out_bits[9]=0, out_bits[17]=0.
REQ-033 Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_bits stable, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-034 Assert rst at E0+2 of a transaction -> out_bits=0, out_valid never rises, coef all zero; a subsequent transaction with the coef table unloaded returns all-zero out_bits.
REQ-035 cfg_we with cfg_addr=2, cfg_data=30'h8000 during EVAL -> coef[2] unchanged; the same write in IDLE, on the same edge as acceptance, is used by that transaction (slice0 bit15=1 -> out_bits[2]=1).
REQ-036 Bench monitor for the duration of all tests: parity operand nonzero only in EVAL and equal to slice dom; in CLR it is 0, and mono_buf slices below dom are 0.

Source files
------------

// File: rtl/tsm_inner_anf_seq.sv
// tsm_inner_anf_seq: share-serial ANF evaluator, one share domain per EVAL cycle.
module tsm_inner_anf_seq #(
    parameter int NUM_SHARES    = 3,
    parameter int NUM_OUT       = 8,
    parameter int CLEAR_BETWEEN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_SHARES*30-1:0]     in_mono,
    input  logic                         cfg_we,
    input  logic [2:0]                   cfg_addr,
    input  logic [29:0]                  cfg_data,
    output logic                         cfg_busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_SHARES*NUM_OUT-1:0] out_bits
);
    localparam int DW = (NUM_SHARES > 1) ? $clog2(NUM_SHARES) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, CLR, DONE} state_t;

    state_t                   state;
    logic [DW-1:0]            dom;
    logic [NUM_SHARES*30-1:0] mono_buf;
    logic [29:0]              coef [NUM_OUT];
    logic [29:0]              operand;
    logic [NUM_OUT-1:0]       par;

    assign in_ready  = state == IDLE;
    assign cfg_busy  = state != IDLE;
    assign out_valid = state == DONE;

    // only the active domain's slice ever reaches the parity trees
    always_comb begin
        operand = (state == EVAL) ? mono_buf[30*dom +: 30] : '0;
        par = '0;
        for (int k = 0; k < NUM_OUT; k++)
            par[k] = ^(coef[k] & operand);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dom      <= '0;
            mono_buf <= '0;
            out_bits <= '0;
            for (int k = 0; k < NUM_OUT; k++)
                coef[k] <= '0;
        end else begin
            if (state == IDLE && cfg_we && int'(cfg_addr) < NUM_OUT)
                coef[cfg_addr] <= cfg_data;
            case (state)
                IDLE: if (in_valid) begin
                    mono_buf <= in_mono;
                    dom      <= '0;
                    state    <= EVAL;
                end
                EVAL: begin
                    out_bits[NUM_OUT*dom +: NUM_OUT] <= par;
                    mono_buf[30*dom +: 30]           <= '0;
                    if (dom == DW'(NUM_SHARES - 1))
                        state <= DONE;
                    else if (CLEAR_BETWEEN != 0)
                        state <= CLR;
                    else
                        dom <= dom + 1'b1;
                end
                CLR: begin
                    dom   <= dom + 1'b1;
                    state <= EVAL;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tsm_inner_anf_seq.sv
// tb_tsm_inner_anf_seq: directed scoreboard bench for the default N=3, NUM_OUT=8, C=1 build.
module tb_tsm_inner_anf_seq;
    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [89:0] in_mono = '0;
    logic        cfg_we = 0;
    logic [2:0]  cfg_addr = '0;
    logic [29:0] cfg_data = '0;
    logic        cfg_busy;
    logic        out_valid;
    logic        out_ready = 0;
    logic [23:0] out_bits;

    int          checks = 0;
    int          failures = 0;
    logic [29:0] mcoef [8];
    logic [23:0] q [$];
    logic [23:0] last_bits;
    logic [29:0] sl;
    bit          mon_on = 0;

    tsm_inner_anf_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_mono(in_mono), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_busy(cfg_busy), .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [89:0] m);
        logic [23:0] r;
        r = '0;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 8; k++)
                r[d*8+k] = ^(mcoef[k] & m[30*d +: 30]);
        return r;
    endfunction

    // operand may only carry the active slice in EVAL; evaluated slices must be wiped
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            sl = dut.mono_buf[30*int'(dut.dom) +: 30];
            chk("mon_operand", dut.operand, (dut.state == 2'd1) ? sl : 30'h0);
            if (dut.state == 2'd1 || dut.state == 2'd2)
                for (int d = 0; d < 3; d++)
                    if (d < int'(dut.dom))
                        chk("mon_wiped", dut.mono_buf[30*d +: 30], 30'h0);
        end
    end

    task automatic cfg(input logic [2:0] a, input logic [29:0] v);
        @(negedge clk);
        cfg_we = 1; cfg_addr = a; cfg_data = v;
        mcoef[a] = v;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic run(input logic [89:0] mono, input bit same_cfg, input bit noise, input int hold);
        int n;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);
        if (same_cfg) begin
            cfg_we = 1; cfg_addr = 3'd2; cfg_data = 30'h8000;
            mcoef[2] = 30'h8000;
        end
        in_valid = 1; in_mono = mono;
        q.push_back(model(mono));
        n = 0;
        do begin
            @(negedge clk);
            n++;
            in_valid = 0; cfg_we = 0; out_ready = 0;
            if (noise && n >= 2 && n <= 4) begin
                in_valid = 1; in_mono = ~mono;
                cfg_we = 1; cfg_addr = 3'd2; cfg_data = 30'h8000;
                out_ready = 1;
            end
        end while (!out_valid && n < 40);
        chk("latency", n, 6);
        last_bits = out_bits;
        chk("result", last_bits, (q.size() > 0) ? q.pop_front() : 24'hx);
        chk("done_busy", cfg_busy, 1);
        chk("done_in_ready", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_bits", out_bits, last_bits);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("released", out_valid, 0);
        chk("idle_again", in_ready, 1);
        chk("bits_kept", out_bits, last_bits);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) mcoef[k] = '0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_bits", out_bits, 0);
        mon_on = 1;

        cfg(3'd0, 30'h1);
        run({30'h1, 30'h0, 30'h1}, 0, 0, 0);
        chk("basic_bits", last_bits, 24'h010001);

        cfg(3'd1, 30'h3FFFFFFF);
        run({30'h0, 30'h3, 30'h7}, 0, 0, 10);
        chk("full_mask_b1", last_bits[1], 1);
        chk("full_mask_b9", last_bits[9], 0);
        chk("full_mask_b17", last_bits[17], 0);

        // busy-time writes, offers and out_ready must all be dropped
        run({30'h8000, 30'h5, 30'h3}, 0, 1, 0);
        chk("busy_write_b18", last_bits[18], 0);

        run({30'h0, 30'h0, 30'h8000}, 1, 0, 0);
        chk("same_edge_b2", last_bits[2], 1);

        cfg(3'd3, 30'h2AAAAAAA);
        run({30'h12345678, 30'h0ABCDEF1, 30'h3FFF0000}, 0, 0, 2);

        @(negedge clk);
        in_valid = 1; in_mono = {30'h1, 30'h1, 30'h1};
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("midrst_bits", out_bits, 0);
        chk("midrst_valid", out_valid, 0);
        rst = 0;
        for (int k = 0; k < 8; k++) mcoef[k] = '0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", cfg_busy, 0);
        begin
            bit seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                seen |= out_valid;
            end
            chk("midrst_no_valid", seen, 0);
        end
        run({30'h3FFFFFFF, 30'h1234567, 30'h7}, 0, 0, 0);
        chk("unloaded_zero", last_bits, 0);

        mon_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
